// File: rtl/spi_pkg.sv
// spi_pkg -- shared definitions for the SPI master.
//   spi_state_t : frame sequencer states
//   FRAME_BITS / ADDR_BITS / DATA_BITS : frame geometry
//   *_MSB / *_LSB / RW_BIT : bit positions inside the 16-bit frame,
//                            which is sent MSB first as {addr, r_or_w, wdata}
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        TAIL,
        HOLD
    } spi_state_t;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_BITS  = 7;
    localparam int DATA_BITS  = 8;

    localparam int FRAME_MSB  = FRAME_BITS - 1;
    localparam int ADDR_MSB   = FRAME_BITS - 1;
    localparam int ADDR_LSB   = FRAME_BITS - ADDR_BITS;
    localparam int RW_BIT     = DATA_BITS;
    localparam int DATA_MSB   = DATA_BITS - 1;
    localparam int DATA_LSB   = 0;

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div -- sclk half-period timer.
// Ports:
//   clk     in  : system clock
//   reset   in  : synchronous active-high reset
//   restart in  : forces the count back to 0 (used on every FSM state change)
//   tick    out : high on the last cycle of each CLK_DIV-cycle period
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV + 1);

    logic [CW-1:0] r_cnt;

    assign tick = (r_cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spi_master.sv
// spi_master -- 16-bit SPI frame master (mode 0, MSB first).
// Frame = {addr[6:0], r_or_w, wdata[7:0]}; the last 8 bits sampled from the
// peripheral land in rdata when the frame ends.
// Ports:
//   clk, reset                : system clock, synchronous active-high reset
//   start, r_or_w, addr, wdata: frame request (start is a one-cycle pulse)
//   busy, done, rdata         : status, end-of-frame pulse, received byte
//   sclk_pin, cs_pin, mosi_pin, miso_pin : SPI pins
// Optional build macro: SPI_MASTER_LOOPBACK_EN -- receive path samples the
// outgoing mosi bit instead of miso_pin.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 r_or_w,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0] wdata,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 sclk_pin,
    output logic                 cs_pin,
    output logic                 mosi_pin,
    input  logic                 miso_pin
);

    spi_state_t r_state, w_next_state;

    logic                  r_sclk;
    logic                  r_done;
    logic [FRAME_BITS-1:0] r_tx;
    logic [4:0]            r_bitcnt;
    logic [DATA_BITS-1:0]  r_rx;
    logic [DATA_BITS-1:0]  r_rdata;

    logic w_tick, w_restart;
    logic w_accept, w_rise, w_fall, w_finish, w_hold_hi, w_hold_lo;
    logic w_rx_bit;

    // Timer restarts on every state change and is parked at 0 while idle.
    assign w_restart = (w_next_state != r_state) || (r_state == IDLE);

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk     (clk),
        .reset   (reset),
        .restart (w_restart),
        .tick    (w_tick)
    );

`ifdef SPI_MASTER_LOOPBACK_EN
    assign w_rx_bit = r_tx[FRAME_MSB];
`else
    assign w_rx_bit = miso_pin;
`endif

    // The first sclk rise coincides with SETUP->SHIFT, so SHIFT ends on the
    // 16th fall after 31 half-periods.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_rise       = 1'b0;
        w_fall       = 1'b0;
        w_finish     = 1'b0;
        w_hold_hi    = 1'b0;
        w_hold_lo    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = SETUP;
                end
            end
            SETUP: begin
                if (w_tick) begin
                    w_rise       = 1'b1;
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (w_tick) begin
                    if (r_sclk) begin
                        w_fall = 1'b1;
                        if (r_bitcnt == 5'(FRAME_BITS - 1)) w_next_state = TAIL;
                    end else begin
                        w_rise = 1'b1;
                    end
                end
            end
            TAIL: begin
                if (w_tick) begin
                    w_finish     = 1'b1;
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                // Low half-period, then one high half-period with cs high so
                // the peripheral's bit counter re-arms.
                if (w_tick) begin
                    if (r_sclk) begin
                        w_hold_lo    = 1'b1;
                        w_next_state = IDLE;
                    end else begin
                        w_hold_hi = 1'b1;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_sclk   <= 1'b0;
            r_done   <= 1'b0;
            r_tx     <= '0;
            r_bitcnt <= '0;
            r_rx     <= '0;
            r_rdata  <= '0;
        end else begin
            r_state <= w_next_state;
            r_done  <= w_finish;
            if (w_accept) begin
                r_tx     <= {addr, r_or_w, wdata};
                r_bitcnt <= '0;
            end
            if (w_rise || w_hold_hi) begin
                r_sclk <= 1'b1;
            end else if (w_fall || w_hold_lo) begin
                r_sclk <= 1'b0;
            end
            if (w_rise) begin
                r_rx <= {r_rx[DATA_BITS-2:0], w_rx_bit};
            end
            // Shifting zeros in leaves mosi low once the frame has gone out.
            if (w_fall) begin
                r_tx     <= {r_tx[FRAME_BITS-2:0], 1'b0};
                r_bitcnt <= r_bitcnt + 5'd1;
            end
            if (w_finish) begin
                r_rdata <= r_rx;
            end
        end
    end

    assign busy     = (r_state != IDLE);
    assign cs_pin   = !((r_state == SETUP) || (r_state == SHIFT) || (r_state == TAIL));
    assign sclk_pin = r_sclk;
    assign mosi_pin = r_tx[FRAME_MSB];
    assign done     = r_done;
    assign rdata    = r_rdata;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master -- self-checking bench for spi_master (CLK_DIV = 2).
// A pin monitor records what appears on the wire (mosi bits at each sclk
// rise, cs low/high run lengths, sclk pulses while cs is high, done pulses)
// and a peripheral model drives miso from a 16-bit word, one bit per rise.
// Expected values come from the frame rules: bits {addr, r_or_w, wdata}
// MSB first, cs low for 33 half-periods, received byte = bits of rises 9..16.
// Build macro: SPI_MASTER_LOOPBACK_EN switches the expected rdata to wdata.
module tb_spi_master;

    localparam int DIV = 2;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       start  = 1'b0;
    logic       r_or_w = 1'b0;
    logic [6:0] addr   = '0;
    logic [7:0] wdata  = '0;
    logic       miso_pin;
    logic       busy, done, sclk_pin, cs_pin, mosi_pin;
    logic [7:0] rdata;

    always #5 clk = ~clk;

    spi_master #(.CLK_DIV(DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .r_or_w   (r_or_w),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .rdata    (rdata),
        .sclk_pin (sclk_pin),
        .cs_pin   (cs_pin),
        .mosi_pin (mosi_pin),
        .miso_pin (miso_pin)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- pin monitor + peripheral ----------------
    logic [15:0] periph_word     = '0;
    logic        prev_sclk       = 1'b0;
    logic        prev_cs         = 1'b1;
    int          rises           = 16;
    int          low_len         = 0;
    int          last_low_len    = 0;
    int          gap_len         = 0;
    int          last_gap_len    = 0;
    int          gap_pulses      = 0;
    int          last_gap_pulses = 0;
    int          n_done          = 0;
    int          n_csfall        = 0;
    logic [15:0] mosi_cap        = '0;
    logic [7:0]  done_rdata      = '0;

    // Peripheral presents the bit for the next rise as soon as the previous
    // rise has been seen.
    assign miso_pin = (rises < 16) ? periph_word[15 - rises] : 1'b0;

    always @(negedge clk) begin
        prev_sclk <= sclk_pin;
        prev_cs   <= cs_pin;
        if (!cs_pin && prev_cs) begin
            n_csfall        <= n_csfall + 1;
            low_len         <= 1;
            mosi_cap        <= '0;
            rises           <= 0;
            last_gap_len    <= gap_len;
            last_gap_pulses <= gap_pulses;
        end else if (!cs_pin) begin
            low_len <= low_len + 1;
            if (sclk_pin && !prev_sclk) begin
                mosi_cap <= {mosi_cap[14:0], mosi_pin};
                rises    <= rises + 1;
            end
        end
        if (cs_pin && !prev_cs) begin
            last_low_len <= low_len;
            gap_len      <= 1;
            gap_pulses   <= 0;
        end else if (cs_pin) begin
            gap_len <= gap_len + 1;
            if (sclk_pin && !prev_sclk) gap_pulses <= gap_pulses + 1;
        end
        if (done) begin
            n_done     <= n_done + 1;
            done_rdata <= rdata;
        end
    end

    // ---------------- reference rules ----------------
    function automatic logic [31:0] exp_frame(input logic rw, input logic [6:0] a,
                                              input logic [7:0] d);
        logic [31:0] f;
        f = 0;
        for (int i = 0; i < 7; i++) f[15 - i] = a[6 - i];
        f[8] = rw;
        for (int i = 0; i < 8; i++) f[7 - i] = d[7 - i];
        return f;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [7:0] d, input logic [15:0] w);
`ifdef SPI_MASTER_LOOPBACK_EN
        return 32'(d);
`else
        return 32'(w[7:0]);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Call at a negedge with busy low; start is taken on the next posedge.
    task automatic launch(input logic rw, input logic [6:0] a, input logic [7:0] d,
                          input logic [15:0] w);
        r_or_w      = rw;
        addr        = a;
        wdata       = d;
        periph_word = w;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_rise", 32'(busy), 1);
        check("cs_fall", 32'(cs_pin), 0);
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 600 && busy; k++) @(negedge clk);
        check(tag, 32'(busy), 0);
    endtask

    task automatic check_frame(input logic rw, input logic [6:0] a, input logic [7:0] d,
                               input logic [15:0] w);
        check("mosi_bits", 32'(mosi_cap), exp_frame(rw, a, d));
        check("cs_low_len", last_low_len, 33 * DIV);
        check("rdata", 32'(rdata), exp_rd(d, w));
        check("rdata_at_done", 32'(done_rdata), exp_rd(d, w));
    endtask

    task automatic run_frame(input logic rw, input logic [6:0] a, input logic [7:0] d,
                             input logic [15:0] w);
        int d0;
        d0 = n_done;
        launch(rw, a, d, w);
        wait_idle("frame_end");
        tick(1);
        check("done_once", n_done - d0, 1);
        check_frame(rw, a, d, w);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          d0, f0, c;
        logic        ps;
        logic        rw;
        logic [6:0]  a;
        logic [7:0]  d;
        logic [15:0] w;

        // Reset state
        reset = 1'b1;
        tick(3);
        check("rst_cs", 32'(cs_pin), 1);
        check("rst_sclk", 32'(sclk_pin), 0);
        check("rst_mosi", 32'(mosi_pin), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rdata", 32'(rdata), 0);
        reset = 1'b0;
        tick(2);

        // Directed write: wire pattern 0010101_0_10100101
        run_frame(1'b0, 7'h15, 8'hA5, 16'h00F0);
        check("mosi_vector", 32'(mosi_cap), 32'h2AA5);

        // Directed read: peripheral sends 3C on rises 9..16
        run_frame(1'b1, 7'h03, 8'hC3, 16'h5A3C);
        tick(30);
        check("rdata_hold", 32'(rdata), exp_rd(8'hC3, 16'h5A3C));

        // start re-pulsed mid-frame is ignored
        d0 = n_done;
        f0 = n_csfall;
        launch(1'b0, 7'h2B, 8'h96, 16'h1234);
        tick(20);
        addr  = 7'h7F;
        wdata = 8'h00;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_idle("midstart_end");
        tick(40 * DIV);
        check("midstart_one_done", n_done - d0, 1);
        check("midstart_one_frame", n_csfall - f0, 1);
        check_frame(1'b0, 7'h2B, 8'h96, 16'h1234);

        // Reset at rising edge 8 aborts without done
        launch(1'b0, 7'h11, 8'h22, 16'hFFFF);
        c  = 0;
        ps = sclk_pin;
        for (int k = 0; k < 400 && c < 8; k++) begin
            @(negedge clk);
            if (sclk_pin && !ps) c++;
            ps = sclk_pin;
        end
        check("reached_rise8", c, 8);
        d0    = n_done;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_cs", 32'(cs_pin), 1);
        check("abort_sclk", 32'(sclk_pin), 0);
        check("abort_busy", 32'(busy), 0);
        tick(50);
        check("abort_no_done", n_done - d0, 0);
        check("abort_rdata", 32'(rdata), 0);
        run_frame(1'b1, 7'h4C, 8'h5E, 16'hA781);

        // Back-to-back: start lands in the first idle cycle after HOLD
        d0 = n_done;
        launch(1'b0, 7'h33, 8'h0F, 16'h00AA);
        wait_idle("b2b_first_end");
        launch(1'b1, 7'h6A, 8'hE1, 16'h0055);
        wait_idle("b2b_second_end");
        tick(1);
        check("b2b_done_count", n_done - d0, 2);
        check("b2b_gap_ge4", 32'(last_gap_len >= 4), 1);
        check("b2b_gap_one_pulse", last_gap_pulses, 1);
        check_frame(1'b1, 7'h6A, 8'hE1, 16'h0055);

        // Randomized frames
        for (int i = 0; i < 8; i++) begin
            rw = 1'($urandom_range(0, 1));
            a  = 7'($urandom);
            d  = 8'($urandom);
            w  = 16'($urandom);
            tick(int'($urandom_range(0, 3)));
            run_frame(rw, a, d, w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
